// File: rtl/id_is_if.sv
// rtl/id_is_if.sv - ID-to-issue handshake, operand and status bundle for id_is_stage.
interface id_is_if #(
   parameter int XLEN = 32
);
   logic            id_valid_in;
   logic            id_ready_out;
   logic [4:0]      id_rs1_addr_in;
   logic [4:0]      id_rs2_addr_in;
   logic [4:0]      id_rd_addr_in;
   logic            id_rd_we_in;
   logic            id_is_load_in;
   logic [XLEN-1:0] id_rs1_data_in;
   logic [XLEN-1:0] id_rs2_data_in;
   logic [1:0]      fwd_mux_sel_in;
   logic [XLEN-1:0] ex_result_in;
   logic            ex_ready_in;
   logic            stall_in;
   logic            flush_in;
   logic            is_valid_out;
   logic [XLEN-1:0] is_rs1_data_out;
   logic [XLEN-1:0] is_rs2_data_out;
   logic [4:0]      is_rd_addr_out;
   logic            is_rd_we_out;
   logic            is_is_load_out;
   logic [7:0]      bubble_cnt_out;

   // The driver of decoded instructions and pipeline control.
   modport master (
      output id_valid_in, id_rs1_addr_in, id_rs2_addr_in, id_rd_addr_in,
             id_rd_we_in, id_is_load_in, id_rs1_data_in, id_rs2_data_in,
             fwd_mux_sel_in, ex_result_in, ex_ready_in, stall_in, flush_in,
      input  id_ready_out, is_valid_out, is_rs1_data_out, is_rs2_data_out,
             is_rd_addr_out, is_rd_we_out, is_is_load_out, bubble_cnt_out
   );

   // The issue stage itself.
   modport slave (
      input  id_valid_in, id_rs1_addr_in, id_rs2_addr_in, id_rd_addr_in,
             id_rd_we_in, id_is_load_in, id_rs1_data_in, id_rs2_data_in,
             fwd_mux_sel_in, ex_result_in, ex_ready_in, stall_in, flush_in,
      output id_ready_out, is_valid_out, is_rs1_data_out, is_rs2_data_out,
             is_rd_addr_out, is_rd_we_out, is_is_load_out, bubble_cnt_out
   );
endinterface

// File: rtl/id_is_stage.sv
// rtl/id_is_stage.sv - ID/IS pipeline register with EX forwarding, load-use bubbles and bubble counter.
module id_is_stage #(
   parameter int XLEN = 32
) (
   input  logic  clk_in,
   input  logic  rst_in,
   id_is_if.slave bus
);
   logic            r_valid;
   logic [XLEN-1:0] r_rs1_data;
   logic [XLEN-1:0] r_rs2_data;
   logic [4:0]      r_rd_addr;
   logic            r_rd_we;
   logic            r_is_load;
   logic [7:0]      r_bubble_cnt;

   logic w_fwd_ok;
   logic w_eff1;
   logic w_eff2;
   logic w_load_use;
   logic w_ready;
   logic w_capture;

   // Forwarding is only meaningful when the held instruction really writes rd.
   assign w_fwd_ok   = r_valid & r_rd_we;
   assign w_eff1     = bus.fwd_mux_sel_in[1] & w_fwd_ok;
   assign w_eff2     = bus.fwd_mux_sel_in[0] & w_fwd_ok;
   assign w_load_use = bus.id_valid_in & r_is_load & (w_eff1 | w_eff2);
   assign w_ready    = ~bus.stall_in & ~bus.flush_in & ~w_load_use &
                       (~r_valid | bus.ex_ready_in);
   assign w_capture  = bus.id_valid_in & w_ready;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_valid      <= 1'b0;
         r_rs1_data   <= '0;
         r_rs2_data   <= '0;
         r_rd_addr    <= '0;
         r_rd_we      <= 1'b0;
         r_is_load    <= 1'b0;
         r_bubble_cnt <= '0;
      end else if (bus.flush_in) begin
         r_valid   <= 1'b0;
         r_rd_we   <= 1'b0;
         r_is_load <= 1'b0;
      end else if (!bus.stall_in) begin
         if (w_capture) begin
            r_valid    <= 1'b1;
            r_rs1_data <= w_eff1 ? bus.ex_result_in : bus.id_rs1_data_in;
            r_rs2_data <= w_eff2 ? bus.ex_result_in : bus.id_rs2_data_in;
            r_rd_addr  <= bus.id_rd_addr_in;
            r_rd_we    <= bus.id_rd_we_in & (bus.id_rd_addr_in != 5'd0);
            r_is_load  <= bus.id_is_load_in;
         end else if (bus.ex_ready_in) begin
            r_valid <= 1'b0;
         end
         if (w_load_use && r_bubble_cnt != 8'hFF) begin
            r_bubble_cnt <= r_bubble_cnt + 8'd1;
         end
      end
   end

   assign bus.id_ready_out    = w_ready;
   assign bus.is_valid_out    = r_valid;
   assign bus.is_rs1_data_out = r_rs1_data;
   assign bus.is_rs2_data_out = r_rs2_data;
   assign bus.is_rd_addr_out  = r_rd_addr;
   assign bus.is_rd_we_out    = r_rd_we;
   assign bus.is_is_load_out  = r_is_load;
   assign bus.bubble_cnt_out  = r_bubble_cnt;
endmodule

// File: tb/tb_id_is_stage.sv
// tb/tb_id_is_stage.sv - directed self-checking bench for id_is_stage.
module tb_id_is_stage;
   logic clk;
   logic rst;
   int   checks;
   int   failures;
   logic [31:0] snap_rs1;
   logic [31:0] snap_rs2;

   id_is_if #(.XLEN(32)) bus ();

   id_is_stage #(.XLEN(32)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we, input logic ld,
                         input logic [31:0] d1, input logic [31:0] d2);
      bus.id_valid_in    = v;
      bus.id_rs1_addr_in = rs1;
      bus.id_rs2_addr_in = rs2;
      bus.id_rd_addr_in  = rd;
      bus.id_rd_we_in    = we;
      bus.id_is_load_in  = ld;
      bus.id_rs1_data_in = d1;
      bus.id_rs2_data_in = d2;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h1111_1111, 32'h2222_2222);
      bus.fwd_mux_sel_in = 2'b00;
      bus.ex_result_in   = 32'h0;
      bus.ex_ready_in    = 1'b1;
      bus.stall_in       = 1'b0;
      bus.flush_in       = 1'b0;
      step();
      step();
      chk("rst_valid", bus.is_valid_out, 0);
      chk("rst_rs1", bus.is_rs1_data_out, 0);
      chk("rst_rd", {bus.is_rd_addr_out, bus.is_rd_we_out, bus.is_is_load_out}, 0);
      chk("rst_bubble", bus.bubble_cnt_out, 0);
      chk("rst_ready_eval", bus.id_ready_out, 1);

      // ADD x5 then SUB x6 = x5 - x3 with EX forwarding into rs1
      rst = 1'b0;
      set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 32'h11, 32'h22);
      #1;
      chk("add_ready", bus.id_ready_out, 1);
      step();
      chk("add_valid", bus.is_valid_out, 1);
      chk("add_rd", {bus.is_rd_addr_out, bus.is_rd_we_out}, {5'd5, 1'b1});
      chk("add_rs1", bus.is_rs1_data_out, 32'h11);
      set_id(1'b1, 5'd5, 5'd3, 5'd6, 1'b1, 1'b0, 32'h55, 32'h33);
      bus.fwd_mux_sel_in = 2'b10;
      bus.ex_result_in   = 32'h0000_00AA;
      #1;
      chk("sub_ready", bus.id_ready_out, 1);
      step();
      chk("sub_rs1_fwd", bus.is_rs1_data_out, 32'h0000_00AA);
      chk("sub_rs2_rf", bus.is_rs2_data_out, 32'h33);
      chk("sub_bubble", bus.bubble_cnt_out, 0);

      // Held instruction without rd write must not forward
      bus.fwd_mux_sel_in = 2'b00;
      set_id(1'b1, 5'd4, 5'd4, 5'd9, 1'b0, 1'b0, 32'h44, 32'h44);
      step();
      bus.fwd_mux_sel_in = 2'b11;
      bus.ex_result_in   = 32'hDEAD_BEEF;
      set_id(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
      step();
      chk("nowe_rs1", bus.is_rs1_data_out, 32'h1234_5678);
      chk("nowe_rs2", bus.is_rs2_data_out, 32'h9ABC_DEF0);
      chk("rd0_we", bus.is_rd_we_out, 0);

      // ex_ready_in low holds the instruction and blocks ID
      bus.fwd_mux_sel_in = 2'b00;
      bus.ex_ready_in    = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("exbusy_ready", bus.id_ready_out, 0);
      step();
      chk("exbusy_valid", bus.is_valid_out, 1);
      bus.ex_ready_in = 1'b1;
      step();
      chk("drain_valid", bus.is_valid_out, 0);

      // Load-use: LW x7 then a consumer of x7 via rs2
      set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 32'h0, 32'h0);
      step();
      chk("lw_load", {bus.is_valid_out, bus.is_is_load_out}, 2'b11);
      set_id(1'b1, 5'd3, 5'd7, 5'd10, 1'b1, 1'b0, 32'h66, 32'h77);
      bus.fwd_mux_sel_in = 2'b01;
      bus.ex_result_in   = 32'h0000_0BAD;
      #1;
      chk("lu_ready", bus.id_ready_out, 0);
      step();
      chk("lu_bubble_valid", bus.is_valid_out, 0);
      chk("lu_bubble_cnt", bus.bubble_cnt_out, 1);
      chk("lu_ready_after", bus.id_ready_out, 1);
      step();
      chk("lu_accept_valid", bus.is_valid_out, 1);
      chk("lu_rs2_rf", bus.is_rs2_data_out, 32'h77);
      chk("lu_cnt_once", bus.bubble_cnt_out, 1);

      // Stall for three cycles with a valid instruction held
      bus.fwd_mux_sel_in = 2'b00;
      bus.stall_in       = 1'b1;
      set_id(1'b1, 5'd1, 5'd2, 5'd11, 1'b1, 1'b0, 32'h100, 32'h200);
      snap_rs1 = bus.is_rs1_data_out;
      snap_rs2 = bus.is_rs2_data_out;
      #1;
      chk("stall_ready", bus.id_ready_out, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_hold", {bus.is_valid_out, bus.is_rd_addr_out, bus.is_rs1_data_out, bus.is_rs2_data_out},
             {1'b1, 5'd10, snap_rs1, snap_rs2});
      end
      bus.stall_in = 1'b0;
      step();
      chk("stall_release", {bus.is_rs1_data_out, bus.is_rd_addr_out}, {32'h100, 5'd11});

      // Flush together with stall while a load-use hazard is pending
      set_id(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 32'h0, 32'h0);
      step();
      set_id(1'b1, 5'd8, 5'd2, 5'd12, 1'b1, 1'b0, 32'h0, 32'h0);
      bus.fwd_mux_sel_in = 2'b10;
      bus.stall_in       = 1'b1;
      bus.flush_in       = 1'b1;
      step();
      chk("flush_valid", {bus.is_valid_out, bus.is_rd_we_out, bus.is_is_load_out}, 3'b000);
      chk("flush_bubble", bus.bubble_cnt_out, 1);
      bus.stall_in = 1'b0;
      bus.flush_in = 1'b0;

      // Saturation: keep a load held with a dependent waiting every cycle
      bus.fwd_mux_sel_in = 2'b00;
      set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 32'h0, 32'h0);
      step();
      bus.ex_ready_in    = 1'b0;
      bus.fwd_mux_sel_in = 2'b01;
      set_id(1'b1, 5'd3, 5'd7, 5'd13, 1'b1, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 253; i++) step();
      chk("sat_254", bus.bubble_cnt_out, 254);
      for (int i = 0; i < 10; i++) step();
      chk("sat_255", bus.bubble_cnt_out, 255);

      rst = 1'b1;
      step();
      chk("rst2_valid", {bus.is_valid_out, bus.is_rd_we_out, bus.is_is_load_out}, 3'b000);
      chk("rst2_data", {bus.is_rs1_data_out, bus.is_rs2_data_out, bus.is_rd_addr_out}, 0);
      chk("rst2_bubble", bus.bubble_cnt_out, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
